// File: rtl/sprx_pkg.sv
// Shared types and widths for the serial parity receiver.
package sprx_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } sprx_state_e;

endpackage

// File: rtl/parity_chk8.sv
// Combinational 8-bit parity checker; flags a mismatch over data plus parity bit.
module parity_chk8
  import sprx_pkg::*;
#(
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              par_i,
  output logic              err_o
);

  localparam logic ODD = (PARITY_ODD != 0);

  // Even parity expects an even count of ones; odd parity inverts that.
  assign err_o = (^{data_i, par_i}) ^ ODD;

endmodule

// File: rtl/serial_parity_rx.sv
// Bit-serial framed byte receiver (start, 8 data LSB first, parity, stop) with a
// one-entry valid/ready output register. Define SPRX_SYNC_EN to add a 2-flop
// synchronizer on sin with bit_en delayed to match.
module serial_parity_rx
  import sprx_pkg::*;
#(
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              sin,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  input  logic              dout_rdy,
  output logic              par_err,
  output logic              frm_err,
  output logic              ovr,
  output logic              busy
);

  logic be;
  logic sd;

`ifdef SPRX_SYNC_EN
  logic [1:0] sin_sync_q;
  logic [1:0] be_dly_q;

  // Synchronizer idles high like the line; the strobe delay idles low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_sync_q <= '1;
      be_dly_q   <= '0;
    end else begin
      sin_sync_q <= {sin_sync_q[0], sin};
      be_dly_q   <= {be_dly_q[0], bit_en};
    end
  end

  assign sd = sin_sync_q[1];
  assign be = be_dly_q[1];
`else
  assign sd = sin;
  assign be = bit_en;
`endif

  sprx_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic              par_q, par_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              vld_q, vld_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              perr_calc;
  logic              complete;

  parity_chk8 #(
    .PARITY_ODD (PARITY_ODD)
  ) u_chk (
    .data_i (sr_q),
    .par_i  (par_q),
    .err_o  (perr_calc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (be) begin
      unique case (state_q)
        IDLE: if (!sd) state_d = DATA;
        DATA: if (cnt_q == CNT_W'(DATA_W - 1)) state_d = PAR;
        PAR:  state_d = STOP;
        STOP: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  assign complete = be && (state_q == STOP);

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    par_d = par_q;
    if (be) begin
      unique case (state_q)
        IDLE: if (!sd) cnt_d = '0;
        DATA: begin
          sr_d  = {sd, sr_q[DATA_W-1:1]};
          cnt_d = cnt_q + CNT_W'(1);
        end
        PAR:     par_d = sd;
        default: ;
      endcase
    end
  end

  // A completion landing on a transfer edge reloads the register and keeps it valid;
  // a completion against a stalled full register is dropped and flagged.
  always_comb begin
    dout_d = dout_q;
    vld_d  = vld_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    ovr_d  = 1'b0;
    if (vld_q && dout_rdy) vld_d = 1'b0;
    if (complete) begin
      if (!vld_q || dout_rdy) begin
        dout_d = sr_q;
        perr_d = perr_calc;
        ferr_d = ~sd;
        vld_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sr_q   <= '0;
      par_q  <= 1'b0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sr_q   <= sr_d;
      par_q  <= par_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      ovr_q  <= ovr_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign par_err  = perr_q;
  assign frm_err  = ferr_q;
  assign ovr      = ovr_q;

endmodule
